// File: rtl/io_bus_ctrl_pkg.sv
// Shared register map, register-select enum and address decode for the
// memory-mapped I/O slave.
package io_bus_ctrl_pkg;

    localparam int DBITS = 16;

    localparam logic [15:0] IO_KDATA = 16'hFFF0;
    localparam logic [15:0] IO_SDATA = 16'hFFF2;
    localparam logic [15:0] IO_KEVT  = 16'hFFF4;
    localparam logic [15:0] IO_TCNT  = 16'hFFF6;
    localparam logic [15:0] IO_HEX   = 16'hFFF8;
    localparam logic [15:0] IO_LEDR  = 16'hFFFA;
    localparam logic [15:0] IO_LEDG  = 16'hFFFC;
    localparam logic [15:0] IO_DEAD  = 16'hDEAD;

    typedef enum logic [2:0] {
        REG_KDATA,
        REG_SDATA,
        REG_KEVT,
        REG_TCNT,
        REG_HEX,
        REG_LEDR,
        REG_LEDG,
        REG_NONE
    } reg_sel_e;

    // Byte address with bit 0 ignored; anything unmapped (including FFFE) is REG_NONE.
    function automatic reg_sel_e decodeAddr(input logic [15:0] addr);
        case ({addr[15:1], 1'b0})
            IO_KDATA: return REG_KDATA;
            IO_SDATA: return REG_SDATA;
            IO_KEVT:  return REG_KEVT;
            IO_TCNT:  return REG_TCNT;
            IO_HEX:   return REG_HEX;
            IO_LEDR:  return REG_LEDR;
            IO_LEDG:  return REG_LEDG;
            default:  return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_bus_ctrl_if.sv
// Core-side data bus seen by the I/O slave: address, store data/strobe and
// combinational read data.
interface io_bus_ctrl_if;
    import io_bus_ctrl_pkg::*;

    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic [DBITS-1:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/io_bus_ctrl_debounce.sv
// Two-flop synchronizer plus per-bit stability counter; a bit is accepted only
// after the synced value has differed from the accepted value for DB_CYCLES edges.
module io_debounce #(
    parameter int             W         = 4,
    parameter int             DB_CYCLES = 250000,
    parameter int             DB_BITS   = 18,
    parameter logic [W-1:0]   RSTVAL    = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_state,
    output logic [W-1:0] o_fall
);

    logic [W-1:0]       r_sync1;
    logic [W-1:0]       r_sync2;
    logic [W-1:0]       r_state;
    logic [DB_BITS-1:0] r_cnt [W];
    logic [W-1:0]       w_expire;

    // A fall pulse coincides with the edge on which an accepted 1 becomes 0.
    always_comb begin
        w_expire = '0;
        for (int i = 0; i < W; i++) begin
            w_expire[i] = (r_sync2[i] != r_state[i]) &&
                          (r_cnt[i] == DB_BITS'(DB_CYCLES - 1));
        end
        o_fall  = w_expire & r_state;
        o_state = r_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= RSTVAL;
            r_sync2 <= RSTVAL;
            r_state <= RSTVAL;
            for (int i = 0; i < W; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < W; i++) begin
                if (r_sync2[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_expire[i]) begin
                    r_state[i] <= ~r_state[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O slave: debounced keys/switches, sticky press flags, tick
// timer and display/LED output registers behind a 0xFFF0-0xFFFE register map.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 250000,
    parameter int DB_BITS   = 18,
    parameter int TICK_DIV  = 50000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    io_bus_ctrl_if.slave  bus,
    input  logic [3:0]    i_key,
    input  logic [9:0]    i_sw,
    output logic [15:0]   o_hexval,
    output logic [9:0]    o_ledr,
    output logic [7:0]    o_ledg
);

    localparam int PS_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [3:0]         w_keyState;
    logic [3:0]         w_keyFall;
    logic [9:0]         w_swState;
    reg_sel_e           w_sel;
    logic               w_tick;
    logic [3:0]         w_kevtClr;

    logic [3:0]         r_kevt;
    logic [15:0]        r_tcnt;
    logic [PS_BITS-1:0] r_presc;
    logic [15:0]        r_hex;
    logic [9:0]         r_ledr;
    logic [7:0]         r_ledg;

    io_debounce #(.W(4), .DB_CYCLES(DB_CYCLES), .DB_BITS(DB_BITS), .RSTVAL(4'hF)) u_keyDb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (i_key),
        .o_state (w_keyState),
        .o_fall  (w_keyFall)
    );

    io_debounce #(.W(10), .DB_CYCLES(DB_CYCLES), .DB_BITS(DB_BITS), .RSTVAL(10'h000)) u_swDb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (i_sw),
        .o_state (w_swState),
        .o_fall  ()
    );

    always_comb begin
        w_sel     = decodeAddr(bus.addr);
        w_tick    = (r_presc == PS_BITS'(TICK_DIV - 1));
        w_kevtClr = (bus.we && w_sel == REG_KEVT) ? bus.wdata[3:0] : 4'h0;
    end

    // Press flags: a new press wins over a simultaneous write-1-to-clear.
    // A timer write restarts the prescaler and overrides a coincident tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_kevt  <= '0;
            r_tcnt  <= '0;
            r_presc <= '0;
            r_hex   <= '0;
            r_ledr  <= '0;
            r_ledg  <= '0;
        end else begin
            r_kevt <= (r_kevt & ~w_kevtClr) | w_keyFall;
            if (bus.we && w_sel == REG_TCNT) begin
                r_tcnt  <= bus.wdata;
                r_presc <= '0;
            end else if (w_tick) begin
                r_tcnt  <= r_tcnt + 1'b1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (bus.we && w_sel == REG_HEX)  r_hex  <= bus.wdata;
            if (bus.we && w_sel == REG_LEDR) r_ledr <= bus.wdata[9:0];
            if (bus.we && w_sel == REG_LEDG) r_ledg <= bus.wdata[7:0];
        end
    end

    always_comb begin
        bus.rdata = IO_DEAD;
        case (w_sel)
            REG_KDATA: bus.rdata = {12'b0, w_keyState};
            REG_SDATA: bus.rdata = {6'b0, w_swState};
            REG_KEVT:  bus.rdata = {12'b0, r_kevt};
            REG_TCNT:  bus.rdata = r_tcnt;
            REG_HEX:   bus.rdata = r_hex;
            REG_LEDR:  bus.rdata = {6'b0, r_ledr};
            REG_LEDG:  bus.rdata = {8'b0, r_ledg};
            default:   bus.rdata = IO_DEAD;
        endcase
    end

    assign o_hexval = r_hex;
    assign o_ledr   = r_ledr;
    assign o_ledg   = r_ledg;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed scenarios plus a randomized run
// against a cycle-count based reference model.
module tb_io_bus_ctrl;

    localparam int DBC  = 4;
    localparam int DBB  = 3;
    localparam int TDIV = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [15:0] hexval;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    int checks   = 0;
    int failures = 0;

    io_bus_ctrl_if busIf ();

    io_bus_ctrl #(.DB_CYCLES(DBC), .DB_BITS(DBB), .TICK_DIV(TDIV)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .bus      (busIf.slave),
        .i_key    (key),
        .i_sw     (sw),
        .o_hexval (hexval),
        .o_ledr   (ledr),
        .o_ledg   (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: inputs reach the debouncer two edges late; a bit is
    // accepted once it has disagreed for DBC consecutive edges; the timer is
    // the loaded value plus elapsed edges divided by TDIV.
    logic [3:0]  mKeyH0, mKeyH1, mKeyAcc, mKevt;
    logic [9:0]  mSwH0, mSwH1, mSwAcc, mLedr;
    logic [15:0] mHex, mTBase;
    logic [7:0]  mLedg;
    int          mKeyRun [4];
    int          mSwRun [10];
    int          mCyc, mTLoad;

    function automatic logic [15:0] mTcnt();
        return 16'(int'(mTBase) + (mCyc - mTLoad) / TDIV);
    endfunction

    function automatic logic [15:0] modelRead(input logic [15:0] a);
        case ({a[15:1], 1'b0})
            16'hFFF0: return {12'b0, mKeyAcc};
            16'hFFF2: return {6'b0, mSwAcc};
            16'hFFF4: return {12'b0, mKevt};
            16'hFFF6: return mTcnt();
            16'hFFF8: return mHex;
            16'hFFFA: return {6'b0, mLedr};
            16'hFFFC: return {8'b0, mLedg};
            default:  return 16'hDEAD;
        endcase
    endfunction

    task automatic modelEdge();
        logic [3:0] newEv;
        logic [3:0] clr;
        if (reset) begin
            mKeyH0 = 4'hF; mKeyH1 = 4'hF; mKeyAcc = 4'hF;
            mSwH0 = '0; mSwH1 = '0; mSwAcc = '0;
            for (int i = 0; i < 4; i++) mKeyRun[i] = 0;
            for (int i = 0; i < 10; i++) mSwRun[i] = 0;
            mKevt = '0; mHex = '0; mLedr = '0; mLedg = '0;
            mCyc = 0; mTLoad = 0; mTBase = '0;
        end else begin
            newEv = '0;
            clr = '0;
            for (int i = 0; i < 4; i++) begin
                if (mKeyH1[i] != mKeyAcc[i]) begin
                    mKeyRun[i]++;
                    if (mKeyRun[i] == DBC) begin
                        mKeyAcc[i] = ~mKeyAcc[i];
                        mKeyRun[i] = 0;
                        if (!mKeyAcc[i]) newEv[i] = 1'b1;
                    end
                end else mKeyRun[i] = 0;
            end
            for (int i = 0; i < 10; i++) begin
                if (mSwH1[i] != mSwAcc[i]) begin
                    mSwRun[i]++;
                    if (mSwRun[i] == DBC) begin
                        mSwAcc[i] = ~mSwAcc[i];
                        mSwRun[i] = 0;
                    end
                end else mSwRun[i] = 0;
            end
            mKeyH1 = mKeyH0; mKeyH0 = key;
            mSwH1 = mSwH0; mSwH0 = sw;
            mCyc++;
            if (busIf.we) begin
                case ({busIf.addr[15:1], 1'b0})
                    16'hFFF4: clr = busIf.wdata[3:0];
                    16'hFFF6: begin mTBase = busIf.wdata; mTLoad = mCyc; end
                    16'hFFF8: mHex = busIf.wdata;
                    16'hFFFA: mLedr = busIf.wdata[9:0];
                    16'hFFFC: mLedg = busIf.wdata[7:0];
                    default: ;
                endcase
            end
            mKevt = (mKevt & ~clr) | newEv;
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
        busIf.addr = a; busIf.wdata = d; busIf.we = 1'b1;
        tick();
        busIf.we = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        busIf.we = 1'b0;
        busIf.addr = a;
        #1;
        d = busIf.rdata;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1; key = 4'hF; sw = '0;
        busIf.we = 1'b0; busIf.addr = '0; busIf.wdata = '0;
        @(negedge clk);
        ticks(2);
        reset = 1'b0;
        checks++; if (hexval !== 16'h0) begin failures++; $display("[TB] FAIL reset_hex: got %h expected 0000", hexval); end
        checks++; if (ledr !== 10'h0) begin failures++; $display("[TB] FAIL reset_ledr: got %h expected 000", ledr); end
        checks++; if (ledg !== 8'h0) begin failures++; $display("[TB] FAIL reset_ledg: got %h expected 00", ledg); end
        peek(16'hFFF0, d);
        checks++; if (d !== 16'h000F) begin failures++; $display("[TB] FAIL reset_kdata: got %h expected 000F", d); end
        peek(16'hFFF4, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL reset_kevt: got %h expected 0000", d); end
        peek(16'hFFFE, d);
        checks++; if (d !== 16'hDEAD) begin failures++; $display("[TB] FAIL reset_fffe: got %h expected DEAD", d); end
        peek(16'hFFF2, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL reset_sdata: got %h expected 0000", d); end
    endtask

    task automatic test_writes();
        logic [15:0] d;
        doWrite(16'hFFF8, 16'h1234);
        doWrite(16'hFFFA, 16'hFFFF);
        doWrite(16'hFFFC, 16'h00A5);
        checks++; if (hexval !== 16'h1234) begin failures++; $display("[TB] FAIL wr_hex: got %h expected 1234", hexval); end
        checks++; if (ledr !== 10'h3FF) begin failures++; $display("[TB] FAIL wr_ledr: got %h expected 3FF", ledr); end
        checks++; if (ledg !== 8'hA5) begin failures++; $display("[TB] FAIL wr_ledg: got %h expected A5", ledg); end
        peek(16'hFFFA, d);
        checks++; if (d !== 16'h03FF) begin failures++; $display("[TB] FAIL rd_ledr: got %h expected 03FF", d); end
        peek(16'hFFFB, d);
        checks++; if (d !== 16'h03FF) begin failures++; $display("[TB] FAIL rd_ledr_odd: got %h expected 03FF", d); end
        peek(16'hFFFC, d);
        checks++; if (d !== 16'h00A5) begin failures++; $display("[TB] FAIL rd_ledg: got %h expected 00A5", d); end
        doWrite(16'hFFF0, 16'h0000);
        peek(16'hFFF0, d);
        checks++; if (d !== 16'h000F) begin failures++; $display("[TB] FAIL kdata_ro: got %h expected 000F", d); end
    endtask

    task automatic test_key_debounce();
        logic [15:0] d;
        key[2] = 1'b0;
        ticks(2);
        key[2] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            peek(16'hFFF0, d);
            checks++; if (d !== 16'h000F) begin failures++; $display("[TB] FAIL glitch_kdata[%0d]: got %h expected 000F", n, d); end
            peek(16'hFFF4, d);
            checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL glitch_kevt[%0d]: got %h expected 0000", n, d); end
        end
        key[2] = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            peek(16'hFFF0, d);
            checks++; if (d !== ((n < 6) ? 16'h000F : 16'h000B)) begin failures++; $display("[TB] FAIL press_kdata[%0d]: got %h expected %h", n, d, (n < 6) ? 16'h000F : 16'h000B); end
            peek(16'hFFF4, d);
            checks++; if (d !== ((n < 6) ? 16'h0000 : 16'h0004)) begin failures++; $display("[TB] FAIL press_kevt[%0d]: got %h expected %h", n, d, (n < 6) ? 16'h0000 : 16'h0004); end
        end
    endtask

    task automatic test_kevt_w1c();
        logic [15:0] d;
        key[0] = 1'b0;
        ticks(5);
        peek(16'hFFF4, d);
        checks++; if (d !== 16'h0004) begin failures++; $display("[TB] FAIL w1c_pre: got %h expected 0004", d); end
        doWrite(16'hFFF4, 16'h0004);
        peek(16'hFFF4, d);
        checks++; if (d !== 16'h0001) begin failures++; $display("[TB] FAIL w1c_setwins: got %h expected 0001", d); end
        peek(16'hFFF0, d);
        checks++; if (d !== 16'h000A) begin failures++; $display("[TB] FAIL w1c_kdata: got %h expected 000A", d); end
        doWrite(16'hFFF4, 16'h0001);
        peek(16'hFFF4, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL w1c_clear: got %h expected 0000", d); end
        key = 4'hF;
        ticks(8);
        peek(16'hFFF4, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL release_noevt: got %h expected 0000", d); end
        peek(16'hFFF0, d);
        checks++; if (d !== 16'h000F) begin failures++; $display("[TB] FAIL release_kdata: got %h expected 000F", d); end
    endtask

    task automatic test_timer();
        logic [15:0] d;
        doWrite(16'hFFF6, 16'hFFFE);
        ticks(2);
        peek(16'hFFF6, d);
        checks++; if (d !== 16'hFFFE) begin failures++; $display("[TB] FAIL tcnt_2: got %h expected FFFE", d); end
        tick();
        peek(16'hFFF6, d);
        checks++; if (d !== 16'hFFFF) begin failures++; $display("[TB] FAIL tcnt_3: got %h expected FFFF", d); end
        ticks(3);
        peek(16'hFFF6, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL tcnt_wrap: got %h expected 0000", d); end
        ticks(2);
        doWrite(16'hFFF6, 16'h1234);
        peek(16'hFFF6, d);
        checks++; if (d !== 16'h1234) begin failures++; $display("[TB] FAIL tcnt_wr_on_tick: got %h expected 1234", d); end
        ticks(2);
        peek(16'hFFF6, d);
        checks++; if (d !== 16'h1234) begin failures++; $display("[TB] FAIL tcnt_presc_clr: got %h expected 1234", d); end
        tick();
        peek(16'hFFF6, d);
        checks++; if (d !== 16'h1235) begin failures++; $display("[TB] FAIL tcnt_after_load: got %h expected 1235", d); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        sw = 10'h155;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        peek(16'hFFF2, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL rst_sdata: got %h expected 0000", d); end
        peek(16'hFFF6, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL rst_tcnt: got %h expected 0000", d); end
        checks++; if (hexval !== 16'h0) begin failures++; $display("[TB] FAIL rst_hex: got %h expected 0000", hexval); end
        ticks(5);
        peek(16'hFFF2, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL rst_sdata_5: got %h expected 0000", d); end
        tick();
        peek(16'hFFF2, d);
        checks++; if (d !== 16'h0155) begin failures++; $display("[TB] FAIL rst_sdata_6: got %h expected 0155", d); end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [15:0] a;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(5) == 0) key[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(5) == 0) sw[$urandom_range(9)] ^= 1'b1;
            reset = ($urandom_range(79) == 0);
            busIf.we = ($urandom_range(2) == 0);
            busIf.addr = ($urandom_range(7) == 0) ? 16'($urandom) : (16'hFFF0 | 16'($urandom_range(15)));
            busIf.wdata = 16'($urandom);
            tick();
            reset = 1'b0;
            busIf.we = 1'b0;
            checks++; if (hexval !== mHex) begin failures++; $display("[TB] FAIL rnd_hex[%0d]: got %h expected %h", n, hexval, mHex); end
            checks++; if (ledr !== mLedr) begin failures++; $display("[TB] FAIL rnd_ledr[%0d]: got %h expected %h", n, ledr, mLedr); end
            checks++; if (ledg !== mLedg) begin failures++; $display("[TB] FAIL rnd_ledg[%0d]: got %h expected %h", n, ledg, mLedg); end
            a = ($urandom_range(7) == 0) ? 16'($urandom) : (16'hFFF0 | 16'($urandom_range(15)));
            peek(a, d);
            checks++; if (d !== modelRead(a)) begin failures++; $display("[TB] FAIL rnd_read[%0d] @%h: got %h expected %h", n, a, d, modelRead(a)); end
            peek(16'hFFF4, d);
            checks++; if (d !== modelRead(16'hFFF4)) begin failures++; $display("[TB] FAIL rnd_kevt[%0d]: got %h expected %h", n, d, modelRead(16'hFFF4)); end
        end
    endtask

    initial begin
        $display("[TB] io_bus_ctrl bench start");
        test_reset();
        test_writes();
        test_key_debounce();
        test_kevt_w1c();
        test_timer();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
